// File: rtl/readback_pkg.sv
// Shared types for the BRAM readback streamer: FSM state encoding, checksum width
// and the checksum step used when READBACK_CHECKSUM_EN is defined.
package readback_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rb_state_t;

  localparam int unsigned CHK_W = 32;

  // Rotate-left-by-one then fold in the next word
  function automatic logic [CHK_W-1:0] chk_step(input logic [CHK_W-1:0] chk,
                                                input logic [CHK_W-1:0] data32);
    return {chk[CHK_W-2:0], chk[CHK_W-1]} ^ data32;
  endfunction

endpackage

// File: rtl/rb_skid_fifo.sv
// Two-entry valid/ready buffer for readback words. The head entry drives the stream
// outputs straight from flops; occupancy is exported so the issuer can hold credit.
module rb_skid_fifo #(
  parameter int unsigned ENTRY_W = 48
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ENTRY_W-1:0] out_data,
  output logic [1:0]         occupancy
);

  logic [ENTRY_W-1:0] slot1;
  logic               pop;

  assign out_valid = (occupancy != 2'd0);
  assign pop       = out_valid & out_ready;

  // Head/second-slot storage; the issuer guarantees no push into a full, non-popping buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupancy <= 2'd0;
      out_data  <= '0;
      slot1     <= '0;
    end else if (flush) begin
      occupancy <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occupancy == 2'd0) out_data <= push_data;
          else                   slot1    <= push_data;
          occupancy <= occupancy + 2'd1;
        end
        2'b01: begin
          out_data  <= slot1;
          occupancy <= occupancy - 2'd1;
        end
        2'b11: begin
          if (occupancy == 2'd1) begin
            out_data <= push_data;
          end else begin
            out_data <= slot1;
            slot1    <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bram_readback_streamer.sv
// Sweeps a 1-cycle-latency BRAM read port over addresses 0..DEPTH_MEM-1 and streams the
// words out on valid/ready with address and last flag.
// Optional: define READBACK_CHECKSUM_EN to add a rolling 32-bit checksum output.
module bram_readback_streamer
  import readback_pkg::*;
#(
  parameter int unsigned WID_MEM   = 36,
  parameter int unsigned DEPTH_MEM = 2048,
  parameter int unsigned ADDR_W    = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  output logic [ADDR_W-1:0]  mem_raddr,
  input  logic [WID_MEM-1:0] mem_dout,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [WID_MEM-1:0] m_data,
  output logic [ADDR_W-1:0]  m_addr,
  output logic               m_last,
  output logic               busy,
  output logic               done
`ifdef READBACK_CHECKSUM_EN
  ,
  output logic [CHK_W-1:0]   checksum
`endif
);

  typedef struct packed {
    logic [WID_MEM-1:0] data;
    logic [ADDR_W-1:0]  addr;
    logic               last;
  } rb_entry_t;

  localparam int unsigned      ENTRY_W   = $bits(rb_entry_t);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_MEM - 1);

  rb_state_t           state;
  logic                infl_vld;
  logic [ADDR_W-1:0]   infl_addr;
  logic                infl_last;
  logic [1:0]          occupancy;
  logic [2:0]          credit_used;
  logic                pop;
  logic                issue;
  logic [ENTRY_W-1:0]  fifo_out;
  rb_entry_t           push_entry;
  rb_entry_t           head;

  assign pop = m_valid & m_ready;

  // Credit counts the slot freed by a pop this cycle so a full-rate stream never bubbles
  assign credit_used = 3'(occupancy) - 3'(pop) + 3'(infl_vld);
  assign issue       = (state == RUN) && !abort && (credit_used < 3'd2);

  assign push_entry = '{data: mem_dout, addr: infl_addr, last: infl_last};
  assign head       = rb_entry_t'(fifo_out);
  assign m_data     = head.data;
  assign m_addr     = head.addr;
  assign m_last     = head.last;

  rb_skid_fifo #(
    .ENTRY_W (ENTRY_W)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (abort),
    .push      (infl_vld),
    .push_data (push_entry),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_data  (fifo_out),
    .occupancy (occupancy)
  );

  // Sweep FSM with read issue, in-flight tracking and registered busy/done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mem_raddr <= '0;
      infl_vld  <= 1'b0;
      infl_addr <= '0;
      infl_last <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      mem_raddr <= '0;
      infl_vld  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      infl_vld <= issue;
      done     <= 1'b0;
      if (issue) begin
        infl_addr <= mem_raddr;
        infl_last <= (mem_raddr == LAST_ADDR);
      end
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            mem_raddr <= '0;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (issue) begin
            if (mem_raddr == LAST_ADDR) state     <= DRAIN;
            else                        mem_raddr <= mem_raddr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (pop && m_last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef READBACK_CHECKSUM_EN
  // Rolling checksum over every accepted word, restarted by an accepted start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checksum <= '0;
    end else if ((state == IDLE) && start && !abort) begin
      checksum <= '0;
    end else if (pop) begin
      checksum <= chk_step(checksum, CHK_W'(m_data));
    end
  end
`endif

endmodule

// File: tb/tb_bram_readback_streamer.sv
// Directed bench for bram_readback_streamer with DEPTH_MEM=16 and a behavioural BRAM.
// Checksum scenario is compiled when READBACK_CHECKSUM_EN is defined.
module tb_bram_readback_streamer;

  localparam int unsigned WID   = 36;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic           clk = 1'b0;
  logic           reset, start, abort, m_ready;
  logic [AW-1:0]  mem_raddr, m_addr;
  logic [WID-1:0] mem_dout, m_data;
  logic           m_valid, m_last, busy, done;
`ifdef READBACK_CHECKSUM_EN
  logic [31:0]    checksum;
`endif

  int tests = 0;
  int fails = 0;

  logic [WID-1:0] mem [DEPTH];

  // Capture results
  int             n_got, done_cnt, done_cyc, first_valid, stall_err;
  bit             timed_out;
  int             got_addr [32];
  logic [WID-1:0] got_data [32];
  logic           got_last [32];
  int             got_cyc  [32];

  bram_readback_streamer #(
    .WID_MEM   (WID),
    .DEPTH_MEM (DEPTH),
    .ADDR_W    (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .mem_raddr (mem_raddr),
    .mem_dout  (mem_dout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_addr    (m_addr),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done)
`ifdef READBACK_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  // Registered-read BRAM model
  always @(posedge clk) mem_dout <= mem[mem_raddr];

  task automatic fill_mem(input int mode);
    for (int i = 0; i < DEPTH; i++)
      mem[i] = (mode == 0) ? WID'(i) : WID'(32'hA5A5_0000 + i);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Runs the stream with a ready pattern until done or the cycle budget; optional extra start pulse
  task automatic capture(input logic [31:0] pat, input int extra_start_at, input int max_cyc);
    int c;
    logic pv;
    logic [WID-1:0] pd;
    logic [AW-1:0] pa;
    logic pl;
    n_got = 0; done_cnt = 0; done_cyc = -1; first_valid = -1; stall_err = 0;
    timed_out = 1'b0; pv = 1'b0; pd = '0; pa = '0; pl = 1'b0; c = 0;
    while (done_cnt == 0 && c < max_cyc) begin
      @(negedge clk);
      c++;
      start = (c == extra_start_at);
      if (done) begin done_cnt++; done_cyc = c; end
      if (pv && (m_valid !== 1'b1 || m_data !== pd || m_addr !== pa || m_last !== pl))
        stall_err++;
      m_ready = pat[c % 32];
      if (m_valid && first_valid < 0) first_valid = c;
      if (m_valid && m_ready) begin
        if (n_got < 32) begin
          got_addr[n_got] = int'(m_addr);
          got_data[n_got] = m_data;
          got_last[n_got] = m_last;
          got_cyc[n_got]  = c;
        end
        n_got++;
        pv = 1'b0;
      end else begin
        pv = m_valid; pd = m_data; pa = m_addr; pl = m_last;
      end
    end
    start = 1'b0;
    if (done_cnt == 0) timed_out = 1'b1;
  endtask

  function automatic int seq_errors();
    int e = 0;
    if (n_got != DEPTH) e++;
    for (int i = 0; i < n_got && i < DEPTH; i++)
      if (got_addr[i] != i || got_data[i] !== mem[i] || got_last[i] !== (i == DEPTH - 1)) e++;
    return e;
  endfunction

  function automatic int gap_errors();
    int e = 0;
    for (int i = 1; i < n_got && i < 32; i++)
      if (got_cyc[i] != got_cyc[0] + i) e++;
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
    fill_mem(0);
    repeat (2) @(negedge clk);
    tests++;
    if ({m_valid, m_last, busy, done} !== 4'b0 || mem_raddr !== '0 || m_addr !== '0 || m_data !== '0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%b last=%b busy=%b done=%b raddr=%0d addr=%0d data=%h, want all 0",
               m_valid, m_last, busy, done, mem_raddr, m_addr, m_data);
    end
`ifdef READBACK_CHECKSUM_EN
    tests++;
    if (checksum !== 32'h0) begin
      fails++; $display("FAIL reset_checksum: got %h want 0", checksum);
    end
`endif
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      fails++; $display("FAIL idle_after_reset: busy=%b valid=%b want 0 0", busy, m_valid);
    end
  endtask

  task automatic test_full_rate();
    fill_mem(0); m_ready = 1'b1;
    pulse_start();
    tests++;
    if (busy !== 1'b1 || mem_raddr !== '0 || m_valid !== 1'b0) begin
      fails++; $display("FAIL t1_start_state: busy=%b raddr=%0d valid=%b want 1 0 0", busy, mem_raddr, m_valid);
    end
    capture(32'hFFFF_FFFF, 0, 100);
    tests++;
    if (timed_out) begin fails++; $display("FAIL t1_timeout: no done within budget"); end
    tests++;
    if (first_valid != 2) begin fails++; $display("FAIL t1_latency: first valid cycle %0d want 2", first_valid); end
    tests++;
    if (seq_errors() != 0) begin fails++; $display("FAIL t1_sequence: %0d errors, %0d words want 16", seq_errors(), n_got); end
    tests++;
    if (gap_errors() != 0) begin fails++; $display("FAIL t1_gaps: %0d gaps want 0", gap_errors()); end
    tests++;
    if (done_cyc != 18) begin fails++; $display("FAIL t1_done_cycle: got %0d want 18", done_cyc); end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || mem_raddr !== 4'd15) begin
      fails++; $display("FAIL t1_after_done: done=%b busy=%b raddr=%0d want 0 0 15", done, busy, mem_raddr);
    end
  endtask

  task automatic test_backpressure();
    fill_mem(0); m_ready = 1'b0;
    pulse_start();
    capture(32'hB36D_94E5, 0, 300);
    tests++;
    if (timed_out || seq_errors() != 0) begin
      fails++; $display("FAIL t2_sequence: timeout=%0d errors=%0d words=%0d want 0 0 16", timed_out, seq_errors(), n_got);
    end
    tests++;
    if (stall_err != 0) begin fails++; $display("FAIL t2_stable: %0d unstable stalls want 0", stall_err); end
  endtask

  task automatic test_stall_then_release();
    fill_mem(0); m_ready = 1'b0;
    pulse_start();
    repeat (20) @(negedge clk);
    tests++;
    if (mem_raddr !== 4'd2 || m_valid !== 1'b1 || m_addr !== 4'd0) begin
      fails++; $display("FAIL t3_hold: raddr=%0d valid=%b addr=%0d want 2 1 0", mem_raddr, m_valid, m_addr);
    end
    capture(32'hFFFF_FFFF, 0, 100);
    tests++;
    if (timed_out || seq_errors() != 0 || gap_errors() != 0) begin
      fails++; $display("FAIL t3_release: timeout=%0d seq=%0d gaps=%0d want 0 0 0", timed_out, seq_errors(), gap_errors());
    end
  endtask

  task automatic test_abort();
    int k;
    int bad;
    fill_mem(0); m_ready = 1'b1;
    pulse_start();
    k = 0;
    while (!(m_valid && m_addr == 4'd5) && k < 40) begin @(negedge clk); k++; end
    tests++;
    if (k >= 40) begin fails++; $display("FAIL t4_reach_word5: word 5 never valid"); end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    tests++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || mem_raddr !== '0) begin
      fails++; $display("FAIL t4_abort: valid=%b busy=%b raddr=%0d want 0 0 0", m_valid, busy, mem_raddr);
    end
    bad = 0;
    repeat (25) begin @(negedge clk); if (done || m_valid) bad++; end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL t4_quiet: %0d cycles with done/valid want 0", bad); end
    pulse_start();
    capture(32'hFFFF_FFFF, 0, 100);
    tests++;
    if (timed_out || seq_errors() != 0) begin
      fails++; $display("FAIL t4_restart: timeout=%0d errors=%0d want 0 0", timed_out, seq_errors());
    end
  endtask

  task automatic test_start_ignored();
    int bad;
    fill_mem(0); m_ready = 1'b1;
    pulse_start();
    capture(32'hFFFF_FFFF, 6, 100);
    tests++;
    if (timed_out || seq_errors() != 0) begin
      fails++; $display("FAIL t5_busy_start: timeout=%0d errors=%0d words=%0d want 0 0 16", timed_out, seq_errors(), n_got);
    end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    tests++;
    if (busy !== 1'b0 || mem_raddr !== 4'd15) begin
      fails++; $display("FAIL t5_done_start: busy=%b raddr=%0d want 0 15", busy, mem_raddr);
    end
    pulse_start();
    repeat (3) @(negedge clk);
    abort = 1'b1; start = 1'b1;
    @(negedge clk); abort = 1'b0; start = 1'b0;
    tests++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || mem_raddr !== '0) begin
      fails++; $display("FAIL t5_abort_wins: busy=%b valid=%b raddr=%0d want 0 0 0", busy, m_valid, mem_raddr);
    end
    bad = 0;
    repeat (5) begin @(negedge clk); if (busy || m_valid || done) bad++; end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL t5_no_sweep: %0d active cycles want 0", bad); end
  endtask

  task automatic test_reset_mid_sweep();
    int bad;
    fill_mem(1); m_ready = 1'b1;
    pulse_start();
    repeat (6) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({m_valid, m_last, busy, done} !== 4'b0 || mem_raddr !== '0 || m_addr !== '0 || m_data !== '0) begin
      fails++;
      $display("FAIL t6_async_reset: valid=%b last=%b busy=%b done=%b raddr=%0d addr=%0d data=%h want all 0",
               m_valid, m_last, busy, done, mem_raddr, m_addr, m_data);
    end
`ifdef READBACK_CHECKSUM_EN
    tests++;
    if (checksum !== 32'h0) begin fails++; $display("FAIL t6_reset_checksum: got %h want 0", checksum); end
`endif
    @(negedge clk); reset = 1'b1;
    bad = 0;
    repeat (4) begin @(negedge clk); if (busy || m_valid) bad++; end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL t6_stays_idle: %0d active cycles want 0", bad); end
  endtask

`ifdef READBACK_CHECKSUM_EN
  task automatic test_checksum();
    logic [31:0] model;
    fill_mem(1); m_ready = 1'b1;
    pulse_start();
    tests++;
    if (checksum !== 32'h0) begin fails++; $display("FAIL t6_chk_clear: got %h want 0", checksum); end
    capture(32'hB36D_94E5, 0, 300);
    model = 32'h0;
    for (int i = 0; i < DEPTH; i++) model = {model[30:0], model[31]} ^ 32'(mem[i]);
    tests++;
    if (timed_out || checksum !== model) begin
      fails++; $display("FAIL t6_checksum: got %h want %h (timeout=%0d)", checksum, model, timed_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_rate();
    test_backpressure();
    test_stall_then_release();
    test_abort();
    test_start_ignored();
    test_reset_mid_sweep();
`ifdef READBACK_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
